// File: rtl/tl_timer_pkg.sv
// tl_timer_pkg: register offsets and field positions
// of the TL-UL machine timer.
package tl_timer_pkg;

  localparam logic [7:0] CTRL_OFFSET        = 8'h00;
  localparam logic [7:0] PRESCALE_OFFSET    = 8'h04;
  localparam logic [7:0] STEP_OFFSET        = 8'h08;
  localparam logic [7:0] MTIME_LO_OFFSET    = 8'h0C;
  localparam logic [7:0] MTIME_HI_OFFSET    = 8'h10;
  localparam logic [7:0] MTIMECMP_LO_OFFSET = 8'h14;
  localparam logic [7:0] MTIMECMP_HI_OFFSET = 8'h18;
  localparam logic [7:0] INTR_STATE_OFFSET  = 8'h1C;
  localparam logic [7:0] INTR_ENABLE_OFFSET = 8'h20;

  localparam int CTRL_EN_BIT    = 0;
  localparam int INTR_TIMER_BIT = 0;

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel types and opcodes shared by
// crossbar and device front ends.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  localparam tl_d_user_t TL_D_USER_DEFAULT = '{
    rsp_intg:  7'h0,
    data_intg: 7'h0
  };

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tl_timer_core.sv
// tl_timer_core: prescaler and 64-bit mtime counter with
// per-half software load.
module tl_timer_core #(
  parameter int PrescaleWidth = 12,
  parameter int StepWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable,
  input  logic [PrescaleWidth-1:0] prescale,
  input  logic [StepWidth-1:0]     step,
  input  logic                     pcnt_clr,
  input  logic                     load_lo,
  input  logic                     load_hi,
  input  logic [31:0]              load_data,
  output logic [63:0]              mtime,
  output logic                     tick
);

  logic [PrescaleWidth-1:0] pcnt;
  logic [63:0]              mtime_d;

  assign tick = enable && (pcnt == prescale);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt <= '0;
    end else if (pcnt_clr || tick) begin
      pcnt <= '0;
    end else if (enable) begin
      pcnt <= pcnt + PrescaleWidth'(1);
    end
  end

  // A software load replaces only its own half, after the tick.
  always_comb begin
    mtime_d = mtime;
    if (tick) begin
      mtime_d = mtime + 64'(step);
    end
    if (load_lo) begin
      mtime_d[31:0] = load_data;
    end
    if (load_hi) begin
      mtime_d[63:32] = load_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= '0;
    end else begin
      mtime <= mtime_d;
    end
  end

endmodule

// File: rtl/tl_timer.sv
// tl_timer: TL-UL machine timer with prescaled 64-bit mtime,
// mtimecmp compare and a level timer interrupt.
module tl_timer
  import tlul_pkg::*;
  import tl_timer_pkg::*;
#(
  parameter int PrescaleWidth = 12,
  parameter int StepWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              intr_timer_o
);

  logic                     rsp_pending;
  logic                     a_ready;
  logic                     a_ack;
  logic                     is_get;
  logic                     is_put;
  logic                     req_err;
  logic                     wr_en;
  logic [7:0]               addr;
  logic [31:0]              wdata;
  logic [31:0]              rdata;

  logic sel_ctrl;
  logic sel_prescale;
  logic sel_step;
  logic sel_mtime_lo;
  logic sel_mtime_hi;
  logic sel_cmp_lo;
  logic sel_cmp_hi;
  logic sel_intr_state;
  logic sel_intr_enable;
  logic sel_any;

  logic                     ctrl_en;
  logic [PrescaleWidth-1:0] prescale;
  logic [StepWidth-1:0]     step;
  logic [63:0]              mtime;
  logic [63:0]              mtimecmp;
  logic                     intr_state;
  logic                     intr_state_d;
  logic                     intr_en;
  logic                     intr_en_d;
  logic                     intr_q;
  logic                     cmp_hit;
  logic                     tick;

  logic [2:0]               rsp_opcode;
  logic [1:0]               rsp_size;
  logic [7:0]               rsp_source;
  logic [31:0]              rsp_data;
  logic                     rsp_error;

  logic                     unused_bits;

  assign a_ready = !rsp_pending;
  assign a_ack   = tl_i.a_valid && a_ready;
  assign addr    = tl_i.a_address[7:0];
  assign wdata   = tl_i.a_data;

  assign sel_ctrl        = addr == CTRL_OFFSET;
  assign sel_prescale    = addr == PRESCALE_OFFSET;
  assign sel_step        = addr == STEP_OFFSET;
  assign sel_mtime_lo    = addr == MTIME_LO_OFFSET;
  assign sel_mtime_hi    = addr == MTIME_HI_OFFSET;
  assign sel_cmp_lo      = addr == MTIMECMP_LO_OFFSET;
  assign sel_cmp_hi      = addr == MTIMECMP_HI_OFFSET;
  assign sel_intr_state  = addr == INTR_STATE_OFFSET;
  assign sel_intr_enable = addr == INTR_ENABLE_OFFSET;

  assign sel_any = sel_ctrl | sel_prescale | sel_step |
                   sel_mtime_lo | sel_mtime_hi |
                   sel_cmp_lo | sel_cmp_hi |
                   sel_intr_state | sel_intr_enable;

  assign is_get = tl_i.a_opcode == Get;
  assign is_put = (tl_i.a_opcode == PutFullData) ||
                  (tl_i.a_opcode == PutPartialData);

  assign req_err = !sel_any ||
                   (tl_i.a_address[1:0] != 2'b00) ||
                   (is_put && (tl_i.a_mask != 4'hF)) ||
                   !(is_get || is_put);

  assign wr_en = a_ack && is_put && !req_err;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl:        rdata[CTRL_EN_BIT] = ctrl_en;
      sel_prescale:    rdata[PrescaleWidth-1:0] = prescale;
      sel_step:        rdata[StepWidth-1:0] = step;
      sel_mtime_lo:    rdata = mtime[31:0];
      sel_mtime_hi:    rdata = mtime[63:32];
      sel_cmp_lo:      rdata = mtimecmp[31:0];
      sel_cmp_hi:      rdata = mtimecmp[63:32];
      sel_intr_state:  rdata[INTR_TIMER_BIT] = intr_state;
      sel_intr_enable: rdata[INTR_TIMER_BIT] = intr_en;
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en  <= 1'b0;
      prescale <= '0;
      step     <= StepWidth'(1);
      mtimecmp <= '1;
    end else if (wr_en) begin
      if (sel_ctrl)     ctrl_en <= wdata[CTRL_EN_BIT];
      if (sel_prescale) prescale <= wdata[PrescaleWidth-1:0];
      if (sel_step)     step <= wdata[StepWidth-1:0];
      if (sel_cmp_lo)   mtimecmp[31:0] <= wdata;
      if (sel_cmp_hi)   mtimecmp[63:32] <= wdata;
    end
  end

  tl_timer_core #(
    .PrescaleWidth(PrescaleWidth),
    .StepWidth(StepWidth)
  ) u_core (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable(ctrl_en),
    .prescale(prescale),
    .step(step),
    .pcnt_clr(wr_en && sel_prescale),
    .load_lo(wr_en && sel_mtime_lo),
    .load_hi(wr_en && sel_mtime_hi),
    .load_data(wdata),
    .mtime(mtime),
    .tick(tick)
  );

  assign cmp_hit = mtime >= mtimecmp;

  // Set beats a coincident W1C clear.
  always_comb begin
    intr_state_d = intr_state;
    intr_en_d    = intr_en;
    if (wr_en && sel_intr_state && wdata[INTR_TIMER_BIT]) begin
      intr_state_d = 1'b0;
    end
    if (cmp_hit) begin
      intr_state_d = 1'b1;
    end
    if (wr_en && sel_intr_enable) begin
      intr_en_d = wdata[INTR_TIMER_BIT];
    end
  end

  // The output gets its own flop so the core sees no AND glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intr_state <= 1'b0;
      intr_en    <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      intr_state <= intr_state_d;
      intr_en    <= intr_en_d;
      intr_q     <= intr_state_d & intr_en_d;
    end
  end

  assign intr_timer_o = intr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_pending <= 1'b0;
      rsp_opcode  <= '0;
      rsp_size    <= '0;
      rsp_source  <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
    end else if (a_ack) begin
      rsp_pending <= 1'b1;
      rsp_opcode  <= is_get ? AccessAckData : AccessAck;
      rsp_size    <= tl_i.a_size;
      rsp_source  <= tl_i.a_source;
      rsp_data    <= (is_get && !req_err) ? rdata : '0;
      rsp_error   <= req_err;
    end else if (rsp_pending && tl_i.d_ready) begin
      rsp_pending <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_pending;
    tl_o.d_opcode = rsp_opcode;
    tl_o.d_size   = rsp_size;
    tl_o.d_source = rsp_source;
    tl_o.d_data   = rsp_data;
    tl_o.d_user   = TL_D_USER_DEFAULT;
    tl_o.d_error  = rsp_error;
    tl_o.a_ready  = a_ready;
  end

  assign unused_bits = ^{tl_i.a_param, tl_i.a_user,
                         tl_i.a_address[31:8], tick};

endmodule

// File: tb/tb_tl_timer.sv
// tb_tl_timer: register vector table plus hand-written
// timing sequences for the TL-UL timer.
module tb_tl_timer;
  import tlul_pkg::*;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic    intr;

  int   applied = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  tl_timer #(
    .PrescaleWidth(12),
    .StepWidth(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .tl_i(tl_i),
    .tl_o(tl_o),
    .intr_timer_o(intr)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add(string name, logic [2:0] op,
                              logic [31:0] addr, logic [31:0] data,
                              logic [3:0] mask, logic [31:0] exp_data,
                              logic exp_err);
    vec_t v;
    v.name = name;
    v.op = op;
    v.addr = addr;
    v.data = data;
    v.mask = mask;
    v.exp_data = exp_data;
    v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic tl_txn(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask,
                        input logic [7:0] src,
                        output logic [31:0] rdata, output logic err,
                        output logic [2:0] dop, output logic [1:0] dsz,
                        output logic [7:0] dsrc);
    int n;
    @(negedge clk);
    tl_i.a_valid = 1'b1;
    tl_i.a_opcode = op;
    tl_i.a_address = addr;
    tl_i.a_data = data;
    tl_i.a_mask = mask;
    tl_i.a_size = 2'd2;
    tl_i.a_source = src;
    n = 0;
    while (!tl_o.a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tl_o.a_ready) begin
      applied++;
      miscompares++;
      $display("FAIL accept timeout: a_ready 0, want 1");
    end
    @(posedge clk);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    n = 0;
    while (!tl_o.d_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tl_o.d_valid) begin
      applied++;
      miscompares++;
      $display("FAIL response timeout: d_valid 0, want 1");
    end
    rdata = tl_o.d_data;
    err = tl_o.d_error;
    dop = tl_o.d_opcode;
    dsz = tl_o.d_size;
    dsrc = tl_o.d_source;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    logic [1:0]  s;
    logic [7:0]  src;
    tl_txn(PutFullData, addr, data, 4'hF, 8'hA0, d, e, o, s, src);
    check("wr err", e, 1'b0);
  endtask

  task automatic rd(input string name, input logic [31:0] addr,
                    input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    logic [1:0]  s;
    logic [7:0]  src;
    tl_txn(Get, addr, 32'h0, 4'hF, 8'hB0, d, e, o, s, src);
    check(name, {e, d}, {1'b0, exp});
  endtask

  task automatic run_vecs();
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    logic [1:0]  s;
    logic [7:0]  src;
    logic [2:0]  exp_op;
    for (int i = 0; i < vecs.size(); i++) begin
      tl_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask,
             8'(i), d, e, o, s, src);
      exp_op = (vecs[i].op == Get) ? AccessAckData : AccessAck;
      applied++;
      if (d !== vecs[i].exp_data || e !== vecs[i].exp_err ||
          o !== exp_op || s !== 2'd2 || src !== 8'(i)) begin
        miscompares++;
        $display("FAIL vec %0d %s: data %h err %b op %0d size %0d src %0d, want data %h err %b op %0d size 2 src %0d",
                 i, vecs[i].name, d, e, o, s, src,
                 vecs[i].exp_data, vecs[i].exp_err, exp_op, i);
      end
    end
  endtask

  initial begin
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst = 1'b1;

    add("rd ctrl", Get, 32'h00, 0, 4'hF, 32'h0, 0);
    add("rd prescale", Get, 32'h04, 0, 4'hF, 32'h0, 0);
    add("rd step", Get, 32'h08, 0, 4'hF, 32'h1, 0);
    add("rd mtime_lo", Get, 32'h0C, 0, 4'hF, 32'h0, 0);
    add("rd mtime_hi", Get, 32'h10, 0, 4'hF, 32'h0, 0);
    add("rd cmp_lo", Get, 32'h14, 0, 4'hF, 32'hFFFF_FFFF, 0);
    add("rd cmp_hi", Get, 32'h18, 0, 4'hF, 32'hFFFF_FFFF, 0);
    add("rd intr_state", Get, 32'h1C, 0, 4'hF, 32'h0, 0);
    add("rd intr_enable", Get, 32'h20, 0, 4'hF, 32'h0, 0);
    add("wr ctrl hi bits", PutFullData, 32'h00, 32'hFFFF_FFFE, 4'hF, 0, 0);
    add("rd ctrl masked", Get, 32'h00, 0, 4'hF, 32'h0, 0);
    add("wr prescale ones", PutFullData, 32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add("rd prescale width", Get, 32'h04, 0, 4'hF, 32'h0000_0FFF, 0);
    add("wr prescale 0", PutFullData, 32'h04, 32'h0, 4'hF, 0, 0);
    add("wr step ones", PutFullData, 32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add("rd step width", Get, 32'h08, 0, 4'hF, 32'h0000_00FF, 0);
    add("wr step 1", PutFullData, 32'h08, 32'h1, 4'hF, 0, 0);
    add("wr intr_en ones", PutFullData, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add("rd intr_en bit", Get, 32'h20, 0, 4'hF, 32'h1, 0);
    add("wr intr_en 0", PutFullData, 32'h20, 32'h0, 4'hF, 0, 0);
    add("partial cmp_lo", PutPartialData, 32'h14, 32'h1234_5678, 4'hF, 0, 0);
    add("rd cmp_lo", Get, 32'h14, 0, 4'hF, 32'h1234_5678, 0);
    add("restore cmp_lo", PutPartialData, 32'h14, 32'hFFFF_FFFF, 4'hF, 0, 0);
    add("wr mtime_hi", PutFullData, 32'h10, 32'hA5A5_A5A5, 4'hF, 0, 0);
    add("rd mtime_hi", Get, 32'h10, 0, 4'hF, 32'hA5A5_A5A5, 0);
    add("clr mtime_hi", PutFullData, 32'h10, 32'h0, 4'hF, 0, 0);
    add("get unmapped", Get, 32'h24, 0, 4'hF, 32'h0, 1);
    add("wr mask 3", PutFullData, 32'h08, 32'h55, 4'h3, 0, 1);
    add("step unchanged", Get, 32'h08, 0, 4'hF, 32'h1, 0);
    add("get misaligned", Get, 32'h02, 0, 4'hF, 32'h0, 1);
    add("bad opcode", 3'h2, 32'h00, 32'h1, 4'hF, 0, 1);
    add("ctrl unchanged", Get, 32'h00, 0, 4'hF, 32'h0, 0);
    add("put unmapped", PutFullData, 32'h24, 32'h1, 4'hF, 0, 1);
    add("partial mask 1", PutPartialData, 32'h04, 32'h7, 4'h1, 0, 1);
    add("prescale unchanged", Get, 32'h04, 0, 4'hF, 32'h0, 0);
    add("put misaligned", PutFullData, 32'h06, 32'h5, 4'hF, 0, 1);
    add("prescale still 0", Get, 32'h04, 0, 4'hF, 32'h0, 0);
    add("get misaligned hi", Get, 32'h1E, 0, 4'hF, 32'h0, 1);

    #2;
    check("rst d_valid", tl_o.d_valid, 1'b0);
    check("rst a_ready", tl_o.a_ready, 1'b1);
    check("rst intr", intr, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_vecs();

    // Prescale 3: one tick per 4 enabled edges, 40 edges enabled.
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    repeat (38) @(negedge clk);
    wr(32'h00, 32'h0);
    rd("mtime after 40", 32'h0C, 32'd10);
    rd("mtime_hi after 40", 32'h10, 32'd0);
    repeat (10) @(negedge clk);
    rd("mtime held disabled", 32'h0C, 32'd10);

    // Wrap: two ticks of 2 from ...FE pass through 0 to 2.
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd2);
    wr(32'h0C, 32'hFFFF_FFFE);
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h14, 32'h0);
    wr(32'h18, 32'h0);
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h0);
    rd("wrap mtime_lo", 32'h0C, 32'd2);
    rd("wrap mtime_hi", 32'h10, 32'd0);
    rd("intr set cmp0", 32'h1C, 32'd1);
    wr(32'h1C, 32'h1);
    rd("w1c cmp0 stays", 32'h1C, 32'd1);

    // Compare at 100, interrupt enabled.
    wr(32'h18, 32'hFFFF_FFFF);
    wr(32'h1C, 32'h1);
    rd("intr cleared", 32'h1C, 32'd0);
    wr(32'h0C, 32'h0);
    wr(32'h14, 32'd100);
    wr(32'h18, 32'h0);
    wr(32'h08, 32'd1);
    wr(32'h20, 32'h1);
    check("intr low before", intr, 1'b0);
    wr(32'h00, 32'h1);
    repeat (100) @(negedge clk);
    check("intr at mtime 100", intr, 1'b0);
    @(negedge clk);
    check("intr cycle after 100", intr, 1'b1);
    repeat (2) @(negedge clk);
    wr(32'h1C, 32'h1);
    check("intr after w1c 105", intr, 1'b1);
    rd("state after w1c 105", 32'h1C, 32'd1);
    wr(32'h00, 32'h0);
    wr(32'h20, 32'h0);
    check("intr masked", intr, 1'b0);
    wr(32'h20, 32'h1);
    check("intr unmasked", intr, 1'b1);
    wr(32'h18, 32'hFFFF_FFFF);
    wr(32'h1C, 32'h1);
    check("intr after clear", intr, 1'b0);
    rd("state after clear", 32'h1C, 32'd0);

    // Response stall: d_ready low 5 cycles, queued second request.
    @(negedge clk);
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1;
    tl_i.a_opcode = Get;
    tl_i.a_address = 32'h14;
    tl_i.a_mask = 4'hF;
    tl_i.a_size = 2'd2;
    tl_i.a_source = 8'h11;
    @(negedge clk);
    tl_i.a_address = 32'h08;
    tl_i.a_source = 8'h22;
    for (int i = 0; i < 5; i++) begin
      check("stall d_valid", tl_o.d_valid, 1'b1);
      check("stall d_data", tl_o.d_data, 32'd100);
      check("stall d_source", tl_o.d_source, 8'h11);
      check("stall a_ready", tl_o.a_ready, 1'b0);
      @(negedge clk);
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    check("after hs d_valid", tl_o.d_valid, 1'b0);
    check("after hs a_ready", tl_o.a_ready, 1'b1);
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check("second d_valid", tl_o.d_valid, 1'b1);
    check("second d_data", tl_o.d_data, 32'd1);
    check("second d_source", tl_o.d_source, 8'h22);
    @(negedge clk);
    check("second done", tl_o.d_valid, 1'b0);

    // Reset with a response pending.
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1;
    tl_i.a_address = 32'h00;
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    check("pending before rst", tl_o.d_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst d_valid", tl_o.d_valid, 1'b0);
    check("async rst a_ready", tl_o.a_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no rsp after rst", tl_o.d_valid, 1'b0);
    tl_i.d_ready = 1'b1;
    rd("cmp_lo after rst", 32'h14, 32'hFFFF_FFFF);
    rd("step after rst", 32'h08, 32'd1);
    rd("mtime after rst", 32'h0C, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
